// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter in front of a single 16-bit adder.
// Add takes one adder pass; subtract takes two (a + ~b, then + 1).

module adder_arbiter_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout
);
  localparam int unsigned W = 16;

  assign {cout, s} = (W + 1)'(a) + (W + 1)'(b);
endmodule

module adder_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout
);
  localparam int unsigned W = 16;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic           op_q, op_d, id_q, id_d, c1_q, c1_d, last_q, last_d;
  logic           cout_q, cout_d, rid_q, rid_d, valid_q, valid_d;
  logic           gnt0, gnt1;
  logic [W-1:0]   add_a, add_b, add_s;
  logic           add_co;

  adder_arbiter_add16 u_add (
    .a    (add_a),
    .b    (add_b),
    .s    (add_s),
    .cout (add_co)
  );

  // Round-robin grant; ready is a same-cycle handshake so it stays combinational.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    acc_d   = acc_q;
    c1_d    = c1_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    rid_d   = rid_q;
    valid_d = valid_q;
    add_a   = a_q;
    add_b   = b_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = PASS1;
        end else if (gnt1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = PASS1;
        end
      end
      PASS1: begin
        add_b = op_q ? ~b_q : b_q;
        acc_d = add_s;
        c1_d  = add_co;
        if (!op_q) begin
          sum_d   = add_s;
          cout_d  = add_co;
          rid_d   = id_q;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          state_d = PASS2;
        end
      end
      PASS2: begin
        // Two's-complement +1; at most one of the two passes can carry.
        add_a   = acc_q;
        add_b   = W'(1);
        sum_d   = add_s;
        cout_d  = c1_q | add_co;
        rid_d   = id_q;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      acc_q   <= '0;
      c1_q    <= 1'b0;
      last_q  <= 1'b1;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rid_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      c1_q    <= c1_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      rid_q   <= rid_d;
      valid_q <= valid_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = rid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule
